seg_scan_driver: RTL



---
 rtl/seg_scan_driver_if.sv | 21 ++
 rtl/seg_scan_driver.sv | 123 ++++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Load handshake between the value producers and the seven-segment scan driver.
interface seg_scan_driver_if;
  logic        load;
  logic [15:0] digit_in;
  logic [3:0]  dp_in;
  logic        load_ack;

  modport master (
    output load,
    output digit_in,
    output dp_in,
    input  load_ack
  );

  modport slave (
    input  load,
    input  digit_in,
    input  dp_in,
    output load_ack
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-boundary commit of new
// values, per-slot anode dead time and optional leading-zero blanking.
module seg_scan_driver #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned DEAD_CYC   = 2
) (
  input  logic              clk_100M,
  input  logic              reset_n,
  seg_scan_driver_if.slave  host,
  input  logic              blank_lz,
  output logic [3:0]        an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic [1:0]    idx;
  logic [15:0]   pend_d;
  logic [3:0]    pend_dp;
  logic          pend_v;
  logic [15:0]   shad_d;
  logic [3:0]    shad_dp;
  logic          commit_q;

  logic          tick;
  logic          dead;
  logic [3:0]    nib;
  logic [3:0]    lz;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick = (div_cnt == CW'(DIV - 1));
  assign dead = (div_cnt < CW'(DEAD_CYC));

  // lz[k]: nibbles 3..k of the shadow are all zero; digit 0 is never blanked
  always_comb begin
    lz    = '0;
    lz[3] = (shad_d[15:12] == 4'h0);
    lz[2] = lz[3] && (shad_d[11:8] == 4'h0);
    lz[1] = lz[2] && (shad_d[7:4] == 4'h0);
    lz[0] = 1'b0;
  end

  always_comb begin
    nib     = shad_d[{idx, 2'b00} +: 4];
    an_nxt  = dead ? 4'b1111 : ~(4'b0001 << idx);
    seg_nxt = (blank_lz && lz[idx]) ? 7'h7F : hex_to_seg(nib);
  end

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt       <= '0;
      idx           <= '0;
      pend_d        <= '0;
      pend_dp       <= '0;
      pend_v        <= 1'b0;
      shad_d        <= '0;
      shad_dp       <= '0;
      commit_q      <= 1'b0;
      an            <= '1;
      seg           <= '1;
      dp            <= 1'b1;
      host.load_ack <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
        if (idx == 2'd3 && pend_v) begin
          shad_d   <= pend_d;
          shad_dp  <= pend_dp;
          pend_v   <= 1'b0;
          commit_q <= 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      // A load coincident with the commit lands after it: the commit took the
      // old pending data, and this later assignment keeps pend_v set.
      if (host.load) begin
        pend_d  <= host.digit_in;
        pend_dp <= host.dp_in;
        pend_v  <= 1'b1;
      end

      // Outputs follow the state one cycle later; the ack is delayed to match so
      // it coincides with slot 0 dead time drawn from the new shadow.
      an            <= an_nxt;
      seg           <= seg_nxt;
      dp            <= ~shad_dp[idx];
      host.load_ack <= commit_q;
    end
  end

endmodule
